despachador: RTL and testbench
==============================

DESPACHADOR -- requirements
Module: despachador

Interface
REQ-001 The block SHALL have parameter ANCHO, default 9, giving the total output word width: 1 valid bit plus ANCHO-1 data bits.
REQ-002 The block SHALL have parameter N, default 2, giving the destination select width (2**N destinations, code 0 = none).
REQ-003 The block SHALL have parameter PROF, default 4, giving the FIFO depth (power of two, at least 2).
REQ-004 The block SHALL have parameter TMAX, default 8, giving the acknowledge timeout in cycles (at least 2).
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 Dato_in  input  ANCHO-1  data payload to enqueue.
REQ-008 Dest_in  input  N  destination code for the payload.
REQ-009 Escribir  input  1  push request, sampled on the rising edge.
REQ-010 Ack  input  2**N  per-destination acknowledge; bit k belongs to destination k.
REQ-011 Salida  output  ANCHO  registered word {valid, data} that feeds the downstream demultiplexer input.
REQ-012 SEL  output  N  registered destination select that feeds the downstream demultiplexer select.
REQ-013 Lleno  output  1  FIFO holds PROF entries.
REQ-014 Vacio  output  1  FIFO holds 0 entries.
REQ-015 Error  output  1  registered one-cycle fault pulse.

Function
REQ-016 The block SHALL buffer {Dest_in, Dato_in} pairs in a PROF-deep FIFO with wrap-around read and write pointers and an occupancy counter of width log2(PROF)+1.
REQ-017 A push SHALL be accepted only when Escribir=1, Lleno=0 (evaluated before the current edge) and Dest_in!=0.
  - This rule holds even if a pop occurs on the same edge.
REQ-018 A push with Lleno=1, or with Dest_in=0, SHALL be discarded with no state change, and Error=1 SHALL be asserted for exactly the next cycle.
REQ-019 A simultaneous accepted push and pop SHALL leave the occupancy unchanged and advance both pointers.
REQ-020 The FSM SHALL have two states, INACTIVO and ENVIAR.
REQ-021 In INACTIVO, the block SHALL drive Salida=0 and SEL=0.
  - If Vacio=0, the block SHALL pop the head entry on that edge, load it into the output registers, and go to ENVIAR.
REQ-022 In ENVIAR, the block SHALL drive Salida={1'b1, data} and SEL=dest, held stable.
  - A cycle counter SHALL start at 0 on entry and increment every cycle.
REQ-023 In ENVIAR, if Ack[SEL]=1 on an edge, the transfer SHALL complete and the block SHALL go to INACTIVO.
  - Salida and SEL SHALL read 0 from the next cycle on, guaranteeing at least one idle cycle between consecutive words.
REQ-024 In ENVIAR, Ack bits other than Ack[SEL] SHALL be ignored.
REQ-025 In ENVIAR, if the counter reaches TMAX-1 without Ack[SEL]=1, the word SHALL be dropped.
  - The block SHALL go to INACTIVO and pulse Error for one cycle.
  - An Ack[SEL] arriving on that same edge SHALL take priority, counting as a completion with no Error.
REQ-026 Latency: a push accepted at edge t into an empty FIFO with the FSM in INACTIVO SHALL produce Salida valid with the correct SEL after edge t+1.
REQ-027 Fault sources on the same edge SHALL OR into a single one-cycle Error pulse.
REQ-028 Lleno and Vacio SHALL be registered and consistent with the occupancy counter every cycle.

Reset
REQ-029 While reset=1 at a rising edge, the block SHALL clear the pointers, occupancy, and timeout counter.
  - FSM SHALL go to INACTIVO.
  - Outputs SHALL be Salida=0, SEL=0, Vacio=1, Lleno=0, Error=0.
REQ-030 Reset during ENVIAR SHALL abandon the in-flight word and all queued words, with no Error pulse.
REQ-031 Escribir and Ack SHALL be ignored on any edge where reset=1.

Verification
REQ-032 Single transfer: after reset, push Dato_in=8'hA5 with Dest_in=2 -> after the next edge Salida=9'h1A5 and SEL=2; assert Ack=4'b0100 -> next cycle Salida=0, SEL=0, Vacio=1.
REQ-033 Back-to-back: push 8'h11 to dest 1, 8'h22 to dest 3, 8'h33 to dest 2 on consecutive cycles, acking each immediately -> words appear in that order, each separated by exactly one idle cycle (SEL=0).
REQ-034 Full/reject: with Ack held 0, push 6 words to dest 1 -> Lleno=1 once 4 words are queued behind the active one.
  - Each further push produces Error=1 for one cycle.
  - Subsequent acks drain exactly the accepted words in order.
REQ-035 Timeout: push 8'h7E to dest 3 with Ack=0 -> Salida stays 9'h17E for TMAX=8 cycles, then returns to 0 with a one-cycle Error pulse.
  - Ack[3] on the final counted cycle completes the transfer with no Error.
REQ-036 Invalid destination and wrong ack: a push with Dest_in=0 -> Error pulse, Vacio stays 1.
  - In ENVIAR with SEL=1, Ack=4'b0100 -> no completion.
REQ-037 Reset mid-operation: 3 words queued and one in ENVIAR, assert reset for one edge -> Salida=0, SEL=0, Vacio=1, Error=0 the next cycle, and no stale words are emitted afterward.

Source files
------------

// File: rtl/despachador.sv
// Dispatcher: queues {destination, data} pairs and presents them one at a time to a
// downstream demultiplexer, waiting for that destination's acknowledge or timing out.
module despachador #(
  parameter int ANCHO = 9,
  parameter int N     = 2,
  parameter int PROF  = 4,
  parameter int TMAX  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ANCHO-2:0]     Dato_in,
  input  logic [N-1:0]         Dest_in,
  input  logic                 Escribir,
  input  logic [(2**N)-1:0]    Ack,
  output logic [ANCHO-1:0]     Salida,
  output logic [N-1:0]         SEL,
  output logic                 Lleno,
  output logic                 Vacio,
  output logic                 Error
);

  localparam int AW = $clog2(PROF);
  localparam int CW = $clog2(TMAX);
  localparam int DW = ANCHO - 1;
  localparam int EW = N + DW;

  typedef enum logic {
    INACTIVO = 1'b0,
    ENVIAR   = 1'b1
  } estado_t;

  estado_t         estado_q;
  logic [EW-1:0]   mem_q [PROF];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            lleno_q, vacio_q, error_q;
  logic [CW-1:0]   tcnt_q;
  logic [ANCHO-1:0] salida_q;
  logic [N-1:0]    sel_q;

  logic            push_s, reject_s, pop_s;
  logic            ack_sel_s, timeout_s;
  logic [EW-1:0]   head_s;

  assign push_s    = Escribir && !lleno_q && (Dest_in != '0);
  assign reject_s  = Escribir && (lleno_q || (Dest_in == '0));
  assign pop_s     = (estado_q == INACTIVO) && !vacio_q;
  assign ack_sel_s = Ack[sel_q];
  assign timeout_s = (estado_q == ENVIAR) && !ack_sel_s && (tcnt_q == CW'(TMAX - 1));
  assign head_s    = mem_q[rptr_q];

  // FIFO pointer and occupancy next-state; pointers wrap because PROF is a power of two
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_s) begin
      wptr_d = wptr_q + AW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + AW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO bookkeeping, registered flags and the merged fault pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      lleno_q <= 1'b0;
      vacio_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      lleno_q <= (cnt_d == (AW+1)'(PROF));
      vacio_q <= (cnt_d == '0);
      error_q <= reject_s | timeout_s;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (!reset && push_s) begin
      mem_q[wptr_q] <= {Dest_in, Dato_in};
    end
  end

  // Transfer FSM with registered demux word/select; an ack on the last counted cycle wins over timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= INACTIVO;
      tcnt_q   <= '0;
      salida_q <= '0;
      sel_q    <= '0;
    end else begin
      case (estado_q)
        INACTIVO: begin
          tcnt_q <= '0;
          if (!vacio_q) begin
            salida_q <= {1'b1, head_s[DW-1:0]};
            sel_q    <= head_s[EW-1:DW];
            estado_q <= ENVIAR;
          end else begin
            salida_q <= '0;
            sel_q    <= '0;
            estado_q <= INACTIVO;
          end
        end
        ENVIAR: begin
          if (ack_sel_s || timeout_s) begin
            salida_q <= '0;
            sel_q    <= '0;
            tcnt_q   <= '0;
            estado_q <= INACTIVO;
          end else begin
            tcnt_q   <= tcnt_q + CW'(1);
            estado_q <= ENVIAR;
          end
        end
        default: begin
          salida_q <= '0;
          sel_q    <= '0;
          tcnt_q   <= '0;
          estado_q <= INACTIVO;
        end
      endcase
    end
  end

  assign Salida = salida_q;
  assign SEL    = sel_q;
  assign Lleno  = lleno_q;
  assign Vacio  = vacio_q;
  assign Error  = error_q;

endmodule

// File: tb/tb_despachador.sv
// Directed bench for despachador: a vector table for the basic flows plus
// hand-written sequences for full/reject, timeout and mid-transfer reset.
module tb_despachador;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Dato_in;
  logic [1:0] Dest_in;
  logic       Escribir;
  logic [3:0] Ack;
  logic [8:0] Salida;
  logic [1:0] SEL;
  logic       Lleno, Vacio, Error;

  int total = 0;
  int bad   = 0;

  despachador #(.ANCHO(9), .N(2), .PROF(4), .TMAX(8)) dut (
    .clk(clk), .reset(reset), .Dato_in(Dato_in), .Dest_in(Dest_in),
    .Escribir(Escribir), .Ack(Ack), .Salida(Salida), .SEL(SEL),
    .Lleno(Lleno), .Vacio(Vacio), .Error(Error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       esc;
    logic [1:0] dest;
    logic [7:0] dato;
    logic [3:0] ack;
    logic [8:0] e_sal;
    logic [1:0] e_sel;
    logic       e_vac;
    logic       e_lle;
    logic       e_err;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic step(input logic rst, input logic esc, input logic [1:0] dest,
                      input logic [7:0] dato, input logic [3:0] ack);
    reset = rst; Escribir = esc; Dest_in = dest; Dato_in = dato; Ack = ack;
    @(posedge clk);
    #1;
    reset = 1'b0; Escribir = 1'b0; Dest_in = 2'd0; Dato_in = 8'h00; Ack = 4'h0;
  endtask

  task automatic chk(input string nm, input logic [8:0] es, input logic [1:0] esl,
                     input logic ev, input logic el, input logic ee);
    total++;
    if ({Salida, SEL, Vacio, Lleno, Error} !== {es, esl, ev, el, ee}) begin
      bad++;
      $display("FAIL %s: got sal=%h sel=%0d vac=%b lle=%b err=%b, want sal=%h sel=%0d vac=%b lle=%b err=%b",
               nm, Salida, SEL, Vacio, Lleno, Error, es, esl, ev, el, ee);
    end
  endtask

  initial begin
    reset = 1'b1; Escribir = 1'b0; Dest_in = 2'd0; Dato_in = 8'h00; Ack = 4'h0;

    //            rst   esc   dest  dato   ack      sal     sel  vac   lle   err
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 9'h1A5, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 2'd1, 8'h11, 4'b0000, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'd3, 8'h22, 4'b0000, 9'h111, 2'd1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 2'd2, 8'h33, 4'b0010, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 9'h122, 2'd3, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1000, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 9'h133, 2'd2, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, 9'h000, 2'd0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 2'd0, 8'h55, 4'b0000, 9'h000, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 2'd1, 8'h44, 4'b0000, 9'h000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, 9'h144, 2'd1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1101, 9'h144, 2'd1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].rst, tbl[i].esc, tbl[i].dest, tbl[i].dato, tbl[i].ack);
      chk($sformatf("vec%0d", i), tbl[i].e_sal, tbl[i].e_sel, tbl[i].e_vac, tbl[i].e_lle, tbl[i].e_err);
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);
    chk("wrongack_done", 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Full/reject: word 1 goes active, words 2..5 fill the FIFO, 6 and 7 are rejected
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, 1'b1, 2'd1, 8'(k), 4'b0000);
      if (k == 5) chk("full_set", 9'h101, 2'd1, 1'b0, 1'b1, 1'b0);
      if (k >= 6) chk($sformatf("full_rej%0d", k), 9'h101, 2'd1, 1'b0, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    chk("full_errclr", 9'h101, 2'd1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);
    chk("full_ack1", 9'h000, 2'd0, 1'b0, 1'b1, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
      chk($sformatf("drain%0d", k), {1'b1, 8'(k)}, 2'd1, (k == 5), 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010);
      chk($sformatf("drain_ack%0d", k), 9'h000, 2'd0, (k == 5), 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    chk("drain_nostale", 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Timeout: valid for 8 cycles, then dropped with an Error pulse
    step(1'b0, 1'b1, 2'd3, 8'h7E, 4'b0000);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
      chk($sformatf("tmo_hold%0d", c), 9'h17E, 2'd3, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    chk("tmo_drop", 9'h000, 2'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    chk("tmo_errclr", 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Ack on the final counted cycle beats the timeout
    step(1'b0, 1'b1, 2'd3, 8'h7E, 4'b0000);
    for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    chk("tmo_last", 9'h17E, 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b1000);
    chk("tmo_lateack", 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
    chk("tmo_lateack_noerr", 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation: one word active, three queued; push/ack on the reset edge ignored
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b1, 2'd2, 8'hC0 + 8'(k), 4'b0000);
    chk("rst_pre", 9'h1C1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd2, 8'hEE, 4'b0100);
    chk("rst_mid", 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);
      chk($sformatf("rst_after%0d", c), 9'h000, 2'd0, 1'b1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
